// File: rtl/fnd_scan_ctrl_pkg.sv
// Shared constants and segment lookup for the FND scan controller.
// Segment bytes are active-low, ordered {dp,g,f,e,d,c,b,a}.
package fnd_scan_ctrl_pkg;

  localparam int unsigned BCD_MAX = 9999;
  localparam int unsigned DP_BIT  = 7;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic [7:0] seg_of_digit(input bcd_digit_t d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fnd_scan_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter: one load cycle then 14 shift cycles,
// done pulses for one cycle and bcd holds until the next start.
module bin2bcd_seq
  import fnd_scan_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  logic [29:0] sr_q, sr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  function automatic logic [15:0] dabble(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start && !busy_q) begin
      sr_d   = {16'd0, bin};
      cnt_d  = 4'd14;
      busy_d = 1'b1;
    end else if (busy_q) begin
      sr_d  = {dabble(sr_q[29:14]), sr_q[13:0]} << 1;
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = sr_q[29:14];

endmodule

// File: rtl/fnd_scan_ctrl.sv
// 4-digit common-anode FND scan controller: prescaler, digit index, per-frame
// snapshot/clamp into a BCD converter, and registered segment output.
module fnd_scan_ctrl
  import fnd_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] value,
  input  logic [3:0]  dot_mask,
  input  logic        blank_lz,
  output logic [1:0]  digit_sel,
  output logic [7:0]  seg,
  output logic        frame_tick,
  output logic        overflow
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    digit_q, digit_d;
  logic [7:0]    seg_q, seg_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   latch_q, latch_d;
  logic          tick;
  logic          over_max;
  logic [13:0]   snap;
  logic          cvt_busy, cvt_done;
  logic [15:0]   cvt_bcd;

  // Leading-zero test walks down from the top digit; digit 0 never blanks.
  function automatic logic [7:0] digit_pattern(input logic [1:0] idx, input logic [15:0] b,
                                               input logic [3:0] dots, input logic blank);
    logic [3:0] lz;
    logic [7:0] p;
    lz[3] = (b[15:12] == 4'd0);
    lz[2] = lz[3] && (b[11:8] == 4'd0);
    lz[1] = lz[2] && (b[7:4] == 4'd0);
    lz[0] = 1'b0;
    p = (blank && lz[idx]) ? SEG_BLANK : seg_of_digit(b[4*idx +: 4]);
    if (dots[idx]) p[DP_BIT] = 1'b0;
    return p;
  endfunction

  assign tick       = (pre_q == PW'(SCAN_DIV - 1));
  assign frame_tick = tick && (digit_q == 2'd3);
  assign over_max   = (value > 14'(BCD_MAX));
  assign snap       = over_max ? 14'(BCD_MAX) : value;

  always_comb begin
    pre_d   = tick ? '0 : pre_q + PW'(1);
    digit_d = tick ? digit_q + 2'd1 : digit_q;
    ovf_d   = frame_tick ? over_max : ovf_q;
    latch_d = cvt_done ? cvt_bcd : latch_q;
    // Pattern is built from the incoming index so seg and digit_sel move together.
    seg_d   = tick ? digit_pattern(digit_d, latch_q, dot_mask, blank_lz) : seg_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q   <= '0;
      digit_q <= '0;
      seg_q   <= SEG_BLANK;
      ovf_q   <= 1'b0;
      latch_q <= '0;
    end else begin
      pre_q   <= pre_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
      ovf_q   <= ovf_d;
      latch_q <= latch_d;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (frame_tick && !cvt_busy),
    .bin   (snap),
    .busy  (cvt_busy),
    .done  (cvt_done),
    .bcd   (cvt_bcd)
  );

  assign digit_sel = digit_q;
  assign seg       = seg_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: a decimal-arithmetic reference model
// queues the expected outputs each clock and a monitor compares them.
module tb_fnd_scan_ctrl;

  localparam int DIV = 20;
  localparam logic [7:0] SEG_TBL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] seg;
    logic       ft;
    logic       ovf;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] value = '0;
  logic [3:0]  dot_mask = '0;
  logic        blank_lz = 1'b0;
  logic [1:0]  digit_sel;
  logic [7:0]  seg;
  logic        frame_tick;
  logic        overflow;

  obs_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  string phase = "reset";

  always #5 clk = ~clk;

  fnd_scan_ctrl #(.SCAN_DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .dot_mask   (dot_mask),
    .blank_lz   (blank_lz),
    .digit_sel  (digit_sel),
    .seg        (seg),
    .frame_tick (frame_tick),
    .overflow   (overflow)
  );

  function automatic logic [7:0] ref_seg(input int idx, input int v, input logic [3:0] dots,
                                         input logic blank);
    int p10;
    logic [7:0] s;
    p10 = 1;
    for (int j = 0; j < idx; j++) p10 = p10 * 10;
    if (blank && idx > 0 && v < p10) s = 8'hFF;
    else s = SEG_TBL[(v / p10) % 10];
    if (dots[idx]) s[7] = 1'b0;
    return s;
  endfunction

  // Reference model: k counts clock edges since reset was released.
  initial begin
    int k, latch, snap, pend;
    bit pend_v;
    logic [7:0] m_seg;
    logic m_ovf;
    obs_t e;
    k = 0; latch = 0; snap = 0; pend = 0; pend_v = 0; m_seg = 8'hFF; m_ovf = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        k = 0; latch = 0; pend_v = 0; m_seg = 8'hFF; m_ovf = 1'b0;
      end else begin
        k++;
        if (pend_v && k == pend) begin
          latch = snap;
          pend_v = 0;
        end
        if (k % (4 * DIV) == 0) begin
          m_ovf  = (int'(value) > 9999);
          snap   = m_ovf ? 9999 : int'(value);
          pend   = k + 15;
          pend_v = 1;
        end
        if (k % DIV == 0) m_seg = ref_seg((k / DIV) % 4, latch, dot_mask, blank_lz);
      end
      e.sel = 2'((k / DIV) % 4);
      e.seg = m_seg;
      e.ft  = ((k % (4 * DIV)) == 4 * DIV - 1);
      e.ovf = m_ovf;
      exp_q.push_back(e);
    end
  end

  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL queue_empty [%s] t=%0t: no expected entry for observed output", phase, $time);
      end else begin
        e = exp_q.pop_front();
        a = {digit_sel, seg, frame_tick, overflow};
        if (a !== e) begin
          n_fail++;
          $display("FAIL scan [%s] t=%0t: got sel=%0d seg=%h ft=%b ovf=%b, expected sel=%0d seg=%h ft=%b ovf=%b",
                   phase, $time, a.sel, a.seg, a.ft, a.ovf, e.sel, e.seg, e.ft, e.ovf);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input string p, input int v, input logic [3:0] d, input logic b, input int n);
    phase = p;
    value = 14'(v);
    dot_mask = d;
    blank_lz = b;
    cycles(n);
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cycles(100);
    set_in("plain",     1234,  4'b0000, 1'b0, 200);
    set_in("blank7",    7,     4'b0000, 1'b1, 200);
    set_in("blank0",    0,     4'b0000, 1'b1, 200);
    set_in("blank1000", 1000,  4'b0000, 1'b1, 200);
    set_in("clamp",     12000, 4'b0000, 1'b0, 200);
    set_in("unclamp",   5,     4'b0000, 1'b0, 200);
    set_in("dp",        1234,  4'b0100, 1'b0, 200);
    set_in("dp_blank",  5,     4'b0100, 1'b1, 200);
    set_in("hold",      1234,  4'b0000, 1'b0, 130);
    set_in("hold_chg",  5678,  4'b0000, 1'b0, 200);

    phase = "reset_mid";
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL frame_tick_wait: got no pulse in 200 cycles, expected one within 80");
    end
    cycles(5);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(120);

    phase = "random";
    for (int i = 0; i < 50; i++) begin
      value    = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 16383))
                                             : 14'($urandom_range(0, 10010));
      dot_mask = 4'($urandom_range(0, 15));
      blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 14) == 0) begin
        reset = 1'b1;
        cycles($urandom_range(1, 3));
        reset = 1'b0;
      end
      cycles($urandom_range(5, 90));
    end
    cycles(200);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
